// File: rtl/mult_pipe_pkg.sv
// Shared constants, control bundle and accumulator-width helper for the
// tiled multiply/MAC pipeline.
package mult_pipe_pkg;

    localparam int TILE_W   = 18;
    localparam int SPLIT    = 17;
    localparam int PROD_W   = 2 * TILE_W;
    localparam int MULT_LAT = 4;

    // Per-op control that travels alongside the data through every stage.
    typedef struct packed {
        logic valid;
        logic acc;
    } ctrl_t;

    function automatic int acc_width(input int width, input int guard);
        return 2 * width + guard;
    endfunction

endpackage

// File: rtl/mul18_tile.sv
// One registered 18x18 signed multiplier with clock enable and synchronous
// active-low clear; the only place vendor DSP mapping belongs.
module mul18_tile
    import mult_pipe_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic signed [TILE_W-1:0] x,
    input  logic signed [TILE_W-1:0] y,
    output logic signed [PROD_W-1:0] p
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p <= '0;
        end else if (en) begin
            p <= x * y;
        end
    end

endmodule

// File: rtl/mult_pipe.sv
// Four-stage pipelined multiply / multiply-accumulate built from four 18x18
// signed tiles, with per-operand signedness, global stall and sticky overflow.
module mult_pipe
    import mult_pipe_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int GUARD = 4,
    localparam int ACC_W = acc_width(WIDTH, GUARD)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_a,
    input  logic             signed_b,
    input  logic             acc,
    output logic             out_valid,
    output logic [ACC_W-1:0] o,
    output logic             ovf
);

    localparam int HI_W  = WIDTH - SPLIT;
    localparam int EXT_W = TILE_W - HI_W;
    localparam int PX_W  = ACC_W - PROD_W;

    if (WIDTH < TILE_W || WIDTH > 2 * SPLIT) begin : g_width_check
        $error("mult_pipe: WIDTH=%0d outside supported range 18..34", WIDTH);
    end

    // S1: operand capture
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             sa_q;
    logic             sb_q;
    ctrl_t            c1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q  <= '0;
            b_q  <= '0;
            sa_q <= 1'b0;
            sb_q <= 1'b0;
            c1   <= '0;
        end else if (en) begin
            a_q      <= a;
            b_q      <= b;
            sa_q     <= signed_a;
            sb_q     <= signed_b;
            c1.valid <= in_valid;
            c1.acc   <= acc;
        end
    end

    // Low halves are forced non-negative so every tile can be a signed 18x18;
    // signedness of the operand is carried entirely by the high half.
    logic signed [TILE_W-1:0] a_lo;
    logic signed [TILE_W-1:0] a_hi;
    logic signed [TILE_W-1:0] b_lo;
    logic signed [TILE_W-1:0] b_hi;

    assign a_lo = {1'b0, a_q[SPLIT-1:0]};
    assign b_lo = {1'b0, b_q[SPLIT-1:0]};
    assign a_hi = {{EXT_W{sa_q & a_q[WIDTH-1]}}, a_q[WIDTH-1:SPLIT]};
    assign b_hi = {{EXT_W{sb_q & b_q[WIDTH-1]}}, b_q[WIDTH-1:SPLIT]};

    // S2: tile products
    logic signed [PROD_W-1:0] p_ll;
    logic signed [PROD_W-1:0] p_lh;
    logic signed [PROD_W-1:0] p_hl;
    logic signed [PROD_W-1:0] p_hh;
    ctrl_t                    c2;

    mul18_tile u_tile_ll (.clk(clk), .rst_n(rst_n), .en(en), .x(a_lo), .y(b_lo), .p(p_ll));
    mul18_tile u_tile_lh (.clk(clk), .rst_n(rst_n), .en(en), .x(a_lo), .y(b_hi), .p(p_lh));
    mul18_tile u_tile_hl (.clk(clk), .rst_n(rst_n), .en(en), .x(a_hi), .y(b_lo), .p(p_hl));
    mul18_tile u_tile_hh (.clk(clk), .rst_n(rst_n), .en(en), .x(a_hi), .y(b_hi), .p(p_hh));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            c2 <= '0;
        end else if (en) begin
            c2 <= c1;
        end
    end

    // S3: recombine partial products; modular ACC_W arithmetic is exact here
    // because the true product always fits in ACC_W signed bits.
    logic [ACC_W-1:0] ll_x;
    logic [ACC_W-1:0] lh_x;
    logic [ACC_W-1:0] hl_x;
    logic [ACC_W-1:0] hh_x;
    logic [ACC_W-1:0] mid_x;
    logic [ACC_W-1:0] prod_d;
    logic [ACC_W-1:0] prod_q;
    ctrl_t            c3;

    assign ll_x   = {{PX_W{p_ll[PROD_W-1]}}, p_ll};
    assign lh_x   = {{PX_W{p_lh[PROD_W-1]}}, p_lh};
    assign hl_x   = {{PX_W{p_hl[PROD_W-1]}}, p_hl};
    assign hh_x   = {{PX_W{p_hh[PROD_W-1]}}, p_hh};
    assign mid_x  = lh_x + hl_x;
    assign prod_d = ll_x + (mid_x << SPLIT) + (hh_x << (2 * SPLIT));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prod_q <= '0;
            c3     <= '0;
        end else if (en) begin
            prod_q <= prod_d;
            c3     <= c2;
        end
    end

    // S4: the output register doubles as the accumulator.
    logic [ACC_W-1:0] sum;
    logic             sum_ovf;

    assign sum     = o + prod_q;
    assign sum_ovf = (o[ACC_W-1] == prod_q[ACC_W-1]) && (sum[ACC_W-1] != o[ACC_W-1]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            o         <= '0;
            ovf       <= 1'b0;
        end else if (en) begin
            out_valid <= c3.valid;
            if (c3.valid) begin
                if (c3.acc) begin
                    o   <= sum;
                    ovf <= ovf | sum_ovf;
                end else begin
                    o   <= prod_q;
                    ovf <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mult_pipe.sv
// Self-checking bench for mult_pipe: directed scenarios plus randomized
// traffic against an arithmetic reference model.
module tb_mult_pipe;

    localparam int WIDTH = 32;
    localparam int GUARD = 4;
    localparam int ACC_W = 2 * WIDTH + GUARD;
    localparam int LAT   = 4;

    // ---------------- clock / reset / DUT ----------------
    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             signed_a;
    logic             signed_b;
    logic             acc;
    logic             out_valid;
    logic [ACC_W-1:0] o;
    logic             ovf;

    always #5 clk = ~clk;

    mult_pipe #(.WIDTH(WIDTH), .GUARD(GUARD)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid),
        .a(a), .b(b), .signed_a(signed_a), .signed_b(signed_b), .acc(acc),
        .out_valid(out_valid), .o(o), .ovf(ovf)
    );

    int n_vec = 0;
    int n_bad = 0;

    // ---------------- reference model / scoreboard ----------------
    // True mathematical product reduced mod 2^ACC_W.
    function automatic logic [ACC_W-1:0] ref_prod(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                                   input logic sx, input logic sy);
        logic [ACC_W-1:0] xe;
        logic [ACC_W-1:0] ye;
        xe = {{(ACC_W-WIDTH){sx & x[WIDTH-1]}}, x};
        ye = {{(ACC_W-WIDTH){sy & y[WIDTH-1]}}, y};
        return xe * ye;
    endfunction

    logic [ACC_W-1:0] exp_q[$];
    logic             exp_ovf_q[$];
    int               due_q[$];
    logic [ACC_W-1:0] m_acc;
    logic             m_ovf;
    logic [ACC_W-1:0] sb_p;
    logic [ACC_W:0]   sb_t;
    int               cyc = 0;
    logic [ACC_W-1:0] e_o;
    logic             e_vld;
    logic             e_ovf;

    // Results are due LAT-1 enabled edges after the edge that accepted them.
    always @(posedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            exp_ovf_q.delete();
            due_q.delete();
            m_acc = '0;
            m_ovf = 1'b0;
            e_o   = '0;
            e_vld = 1'b0;
            e_ovf = 1'b0;
        end else if (en) begin
            cyc++;
            e_vld = 1'b0;
            if (due_q.size() > 0 && due_q[0] == cyc) begin
                void'(due_q.pop_front());
                e_o   = exp_q.pop_front();
                e_ovf = exp_ovf_q.pop_front();
                e_vld = 1'b1;
            end
            if (in_valid) begin
                sb_p = ref_prod(a, b, signed_a, signed_b);
                if (acc) begin
                    sb_t  = {m_acc[ACC_W-1], m_acc} + {sb_p[ACC_W-1], sb_p};
                    m_acc = sb_t[ACC_W-1:0];
                    if (sb_t[ACC_W] != sb_t[ACC_W-1]) m_ovf = 1'b1;
                end else begin
                    m_acc = sb_p;
                    m_ovf = 1'b0;
                end
                exp_q.push_back(m_acc);
                exp_ovf_q.push_back(m_ovf);
                due_q.push_back(cyc + LAT - 1);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                          input logic sx, input logic sy, input logic ac, input logic v);
        a        = x;
        b        = y;
        signed_a = sx;
        signed_b = sy;
        acc      = ac;
        in_valid = v;
    endtask

    task automatic drive(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                         input logic sx, input logic sy, input logic ac, input logic v);
        @(negedge clk);
        set_op(x, y, sx, sy, ac, v);
    endtask

    task automatic idle();
        drive('0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    function automatic logic [WIDTH-1:0] rand_opnd();
        case ($urandom_range(0, 4))
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return WIDTH'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b1;
        set_op('0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        n_vec++; if (o !== '0)          begin n_bad++; $display("FAIL reset_o: got %h want 0", o); end
        n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_vec++; if (ovf !== 1'b0)       begin n_bad++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        rst_n = 1'b1;
    endtask

    task automatic test_single(input string name, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                               input logic sx, input logic sy, input logic [ACC_W-1:0] want);
        drive(x, y, sx, sy, 1'b0, 1'b1);
        repeat (3) idle();
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL %s_valid: got %b want 1", name, out_valid); end
        n_vec++; if (o !== want)         begin n_bad++; $display("FAIL %s_o: got %h want %h", name, o, want); end
        n_vec++; if (ovf !== 1'b0)       begin n_bad++; $display("FAIL %s_ovf: got %b want 0", name, ovf); end
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL %s_pulse: got %b want 0", name, out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [ACC_W-1:0] want [3];
        want[0] = 68'd12;
        want[1] = 68'd42;
        want[2] = 68'd28;
        drive(32'd3, 32'd4, 1'b1, 1'b1, 1'b0, 1'b1);
        drive(32'd5, 32'd6, 1'b1, 1'b1, 1'b1, 1'b1);
        drive(32'hFFFF_FFFE, 32'd7, 1'b1, 1'b1, 1'b1, 1'b1);
        idle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++;
            if (out_valid !== 1'b1 || o !== want[i]) begin
                n_bad++;
                $display("FAIL b2b_%0d: got valid=%b o=%h want valid=1 o=%h", i, out_valid, o, want[i]);
            end
        end
    endtask

    // 2^62 repeatedly: the 32nd running sum reaches 2^67 and overflows.
    task automatic test_overflow();
        logic [ACC_W-1:0] want;
        logic             want_ovf;
        int               k;
        for (int i = 0; i < 38; i++) begin
            @(negedge clk);
            if (i >= LAT) begin
                k        = i - LAT;
                want     = (k == 33) ? ACC_W'(12) : ({{(ACC_W-32){1'b0}}, 32'(k + 1)} << 62);
                want_ovf = (k == 31 || k == 32);
                n_vec++; if (o !== want)       begin n_bad++; $display("FAIL ovf_seq_o_%0d: got %h want %h", k, o, want); end
                n_vec++; if (ovf !== want_ovf) begin n_bad++; $display("FAIL ovf_seq_flag_%0d: got %b want %b", k, ovf, want_ovf); end
            end
            if (i < 33)       set_op(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, i != 0, 1'b1);
            else if (i == 33) set_op(32'd3, 32'd4, 1'b1, 1'b1, 1'b0, 1'b1);
            else              set_op('0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_stall_reset();
        drive(32'd5, 32'd5, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(32'd1, 32'd1, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(32'd2, 32'd2, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(32'd3, 32'd3, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b1 || o !== 68'd25) begin n_bad++; $display("FAIL stall_pre: got valid=%b o=%h want valid=1 o=19", out_valid, o); end
        en = 1'b0;
        set_op(32'd9, 32'd9, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++;
            if (out_valid !== 1'b1 || o !== 68'd25 || ovf !== 1'b0) begin
                n_bad++;
                $display("FAIL stall_hold_%0d: got valid=%b o=%h ovf=%b want valid=1 o=19 ovf=0", i, out_valid, o, ovf);
            end
        end
        en    = 1'b1;
        rst_n = 1'b0;
        set_op('0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            n_vec++;
            if (out_valid !== 1'b0 || o !== '0 || ovf !== 1'b0) begin
                n_bad++;
                $display("FAIL post_reset_%0d: got valid=%b o=%h ovf=%b want 0/0/0", i, out_valid, o, ovf);
            end
            @(negedge clk);
        end
        set_op(32'd2, 32'd3, 1'b0, 1'b0, 1'b1, 1'b1);
        repeat (3) idle();
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b1 || o !== 68'd6) begin n_bad++; $display("FAIL acc_after_reset: got valid=%b o=%h want valid=1 o=6", out_valid, o); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            n_vec++;
            if (out_valid !== e_vld || o !== e_o || ovf !== e_ovf) begin
                n_bad++;
                $display("FAIL random_%0d: got valid=%b o=%h ovf=%b want valid=%b o=%h ovf=%b",
                         i, out_valid, o, ovf, e_vld, e_o, e_ovf);
            end
            en = (i >= 392) || ($urandom_range(0, 7) != 0);
            if (i < 390)
                set_op(rand_opnd(), rand_opnd(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       $urandom_range(0, 9) < 7, $urandom_range(0, 4) != 0);
            else
                set_op('0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single("signed_neg1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 68'd1);
        test_single("unsigned_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, {4'h0, 64'hFFFF_FFFE_0000_0001});
        test_single("mixed_sign", 32'hFFFF_FFFE, 32'd3, 1'b1, 1'b0, ~{{(ACC_W-3){1'b0}}, 3'd5});
        test_back_to_back();
        test_overflow();
        test_stall_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete within 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
